// File: rtl/srsc_recombine_if.sv
// Handshake bundle between the SRSC channel multiplier side and the J consumer.
// Master drives issue/product/out_ready; slave is the recombine block.
interface srsc_recombine_if;
  logic       in_valid;
  logic       in_ready;
  logic       in_sign;
  logic [7:0] in_ac;
  logic [7:0] product;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_j;
  logic       out_last;
  logic       frame_done;

  modport master (
    output in_valid, in_sign, in_ac, product, out_ready,
    input  in_ready, out_valid, out_j, out_last, frame_done
  );

  modport slave (
    input  in_valid, in_sign, in_ac, product, out_ready,
    output in_ready, out_valid, out_j, out_last, frame_done
  );
endinterface

// File: rtl/srsc_recombine.sv
// Recombines the saturated |Ic-Ac|/t product with Ac into radiance J, aligns
// side-band data to the multiplier latency and buffers J in a credit-guarded FWFT FIFO.
module srsc_recombine #(
  parameter int unsigned MULT_LAT   = 2,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned IMG_W      = 512,
  parameter int unsigned IMG_H      = 512
) (
  input  logic            clk,
  input  logic            rst,
  srsc_recombine_if.slave bus
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned IW = $clog2(MULT_LAT + 2);
  localparam int unsigned XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int unsigned L  = MULT_LAT - 1;

  logic          issue;
  logic [XW-1:0] col;
  logic [YW-1:0] row;
  logic          col_end;
  logic          row_end;

  logic [MULT_LAT-1:0] pv;
  logic [MULT_LAT-1:0] ps;
  logic [MULT_LAT-1:0] pl;
  logic [7:0]          pa [MULT_LAT];

  logic [8:0] sum;
  logic [8:0] diff;
  logic [7:0] j_next;

  logic       r_valid;
  logic [7:0] r_j;
  logic       r_last;

  logic [IW-1:0] inflight;

  logic [8:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [8:0]    head;
  logic          pop;
  logic          frame_done_q;

  // Credit covers everything between issue and FIFO write, so the
  // non-stallable multiplier can never push into a full FIFO.
  assign bus.in_ready = (int'(count) + int'(inflight)) < int'(FIFO_DEPTH);
  assign issue        = bus.in_valid & bus.in_ready;

  assign col_end = (col == XW'(IMG_W - 1));
  assign row_end = (row == YW'(IMG_H - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col <= '0;
      row <= '0;
    end else if (issue) begin
      if (col_end) begin
        col <= '0;
        row <= row_end ? '0 : row + YW'(1);
      end else begin
        col <= col + XW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pv <= '0;
      ps <= '0;
      pl <= '0;
      for (int unsigned i = 0; i < MULT_LAT; i++) pa[i] <= '0;
    end else begin
      pv[0] <= issue;
      ps[0] <= bus.in_sign;
      pa[0] <= bus.in_ac;
      pl[0] <= col_end & row_end;
      for (int unsigned i = 1; i < MULT_LAT; i++) begin
        pv[i] <= pv[i-1];
        ps[i] <= ps[i-1];
        pa[i] <= pa[i-1];
        pl[i] <= pl[i-1];
      end
    end
  end

  always_comb begin
    sum  = {1'b0, pa[L]} + {1'b0, bus.product};
    diff = {1'b0, pa[L]} - {1'b0, bus.product};
    if (ps[L]) j_next = diff[8] ? '0 : diff[7:0];
    else       j_next = sum[8]  ? '1 : sum[7:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid  <= 1'b0;
      r_j      <= '0;
      r_last   <= 1'b0;
      inflight <= '0;
    end else begin
      r_valid  <= pv[L];
      r_j      <= j_next;
      r_last   <= pl[L];
      inflight <= inflight + IW'(issue) - IW'(r_valid);
    end
  end

  assign pop  = bus.out_valid & bus.out_ready;
  assign head = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (r_valid) mem[wr_ptr] <= {r_j, r_last};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      if (r_valid) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      count        <= count + CW'(r_valid) - CW'(pop);
      frame_done_q <= pop & head[0];
    end
  end

  assign bus.out_valid  = (count != '0);
  assign bus.out_j      = bus.out_valid ? head[8:1] : '0;
  assign bus.out_last   = bus.out_valid & head[0];
  assign bus.frame_done = frame_done_q;

endmodule
